// File: rtl/iter_calculator_if.sv
// Request/result handshake bundle for iter_calculator.
// The master drives requests and result acceptance; the slave is the calculator.
interface iter_calculator_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] aux;
    logic             dz;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, aux, dz
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, aux, dz
    );
endinterface

// File: rtl/iter_calculator.sv
// Multi-cycle unsigned calculator sharing one WIDTH-bit adder between
// add, subtract, shift-add multiply and restoring division.
module iter_calculator #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    iter_calculator_if.slave   bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] aux_q;
    logic             dz_q;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] b_q;
    // hi is the upper product half or the partial remainder; lo holds the
    // multiplier or dividend and fills with low product / quotient bits.
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   mul_full;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic             div_ok;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;

    // Operand steering into the single shared adder.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        shifted = {hi, lo[WIDTH-1]};
        case (op_q)
            OP_ADD: begin
                add_a = lo;
                add_b = b_q;
            end
            OP_SUB: begin
                add_a   = lo;
                add_b   = ~b_q;
                add_cin = 1'b1;
            end
            OP_MUL: begin
                add_a = hi;
                add_b = b_q;
            end
            default: begin
                add_a   = shifted[WIDTH-1:0];
                add_b   = ~b_q;
                add_cin = 1'b1;
            end
        endcase
        sum = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+1)'(add_cin);
    end

    // Next-step values for one multiply or divide iteration.
    always_comb begin
        mul_full = lo[0] ? sum : {1'b0, hi};
        mul_hi   = mul_full[WIDTH:1];
        mul_lo   = {mul_full[0], lo[WIDTH-1:1]};
        div_ok   = shifted[WIDTH] | sum[WIDTH];
        div_hi   = div_ok ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
        div_lo   = {lo[WIDTH-2:0], div_ok};
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            aux_q       <= '0;
            dz_q        <= 1'b0;
            cnt         <= '0;
            op_q        <= OP_ADD;
            b_q         <= '0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        op_q       <= bus.op;
                        b_q        <= bus.b;
                        lo         <= bus.a;
                        hi         <= '0;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    case (op_q)
                        OP_ADD: begin
                            result_q <= sum[WIDTH-1:0];
                            aux_q    <= {{(WIDTH-1){1'b0}}, sum[WIDTH]};
                            dz_q     <= 1'b0;
                            state    <= DONE;
                        end
                        OP_SUB: begin
                            result_q <= sum[WIDTH-1:0];
                            aux_q    <= {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
                            dz_q     <= 1'b0;
                            state    <= DONE;
                        end
                        OP_MUL: begin
                            hi  <= mul_hi;
                            lo  <= mul_lo;
                            cnt <= cnt + 1'b1;
                            if (cnt == LAST) begin
                                result_q <= mul_lo;
                                aux_q    <= mul_hi;
                                dz_q     <= 1'b0;
                                state    <= DONE;
                            end
                        end
                        default: begin
                            if (b_q == '0) begin
                                result_q <= '1;
                                aux_q    <= lo;
                                dz_q     <= 1'b1;
                                state    <= DONE;
                            end else begin
                                hi  <= div_hi;
                                lo  <= div_lo;
                                cnt <= cnt + 1'b1;
                                if (cnt == LAST) begin
                                    result_q <= div_lo;
                                    aux_q    <= div_hi;
                                    dz_q     <= 1'b0;
                                    state    <= DONE;
                                end
                            end
                        end
                    endcase
                end
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.aux       = aux_q;
    assign bus.dz        = dz_q;

endmodule

// File: tb/tb_iter_calculator.sv
// Directed testbench for iter_calculator at WIDTH 8, 16 and 2,
// using a hand-computed vector table plus a reference model.
module tb_iter_calculator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    iter_calculator_if #(.WIDTH(8))  bus8 ();
    iter_calculator_if #(.WIDTH(16)) bus16 ();
    iter_calculator_if #(.WIDTH(2))  bus2 ();

    iter_calculator #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    iter_calculator #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    iter_calculator #(.WIDTH(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int          sel = 8;
    logic        drv_valid = 1'b0;
    logic [1:0]  drv_op = 2'd0;
    logic [31:0] drv_a = '0;
    logic [31:0] drv_b = '0;
    logic        drv_out_ready = 1'b0;

    assign bus8.in_valid   = drv_valid && (sel == 8);
    assign bus8.op         = drv_op;
    assign bus8.a          = drv_a[7:0];
    assign bus8.b          = drv_b[7:0];
    assign bus8.out_ready  = drv_out_ready;
    assign bus16.in_valid  = drv_valid && (sel == 16);
    assign bus16.op        = drv_op;
    assign bus16.a         = drv_a[15:0];
    assign bus16.b         = drv_b[15:0];
    assign bus16.out_ready = drv_out_ready;
    assign bus2.in_valid   = drv_valid && (sel == 2);
    assign bus2.op         = drv_op;
    assign bus2.a          = drv_a[1:0];
    assign bus2.b          = drv_b[1:0];
    assign bus2.out_ready  = drv_out_ready;

    logic        cur_in_ready;
    logic        cur_out_valid;
    logic [31:0] cur_result;
    logic [31:0] cur_aux;
    logic        cur_dz;

    // Route the selected instance's outputs to one set of observation signals.
    always_comb begin
        cur_in_ready  = bus8.in_ready;
        cur_out_valid = bus8.out_valid;
        cur_result    = 32'(bus8.result);
        cur_aux       = 32'(bus8.aux);
        cur_dz        = bus8.dz;
        if (sel == 16) begin
            cur_in_ready  = bus16.in_ready;
            cur_out_valid = bus16.out_valid;
            cur_result    = 32'(bus16.result);
            cur_aux       = 32'(bus16.aux);
            cur_dz        = bus16.dz;
        end else if (sel == 2) begin
            cur_in_ready  = bus2.in_ready;
            cur_out_valid = bus2.out_valid;
            cur_result    = 32'(bus2.result);
            cur_aux       = 32'(bus2.aux);
            cur_dz        = bus2.dz;
        end
    end

    int checks = 0;
    int fails  = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Accepts one request and returns once out_valid is seen (or the bound expires).
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!cur_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        drv_valid = 1'b1;
        drv_op    = op;
        drv_a     = a;
        drv_b     = b;
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        drv_op    = ~op;
        drv_a     = ~a;
        drv_b     = ~b;
        lat = 0;
        while (!cur_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume(input string name);
        drv_out_ready = 1'b1;
        @(negedge clk);
        drv_out_ready = 1'b0;
        checkOutput({name, " out_valid drop"}, 32'(cur_out_valid), 32'd0);
    endtask

    task automatic doVector(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] er, input logic [31:0] ex,
                            input logic ez, input int elat);
        int lat;
        applyStimulus(op, a, b, lat);
        checkOutput({name, " latency"}, 32'(lat), 32'(elat));
        checkOutput({name, " result"}, cur_result, er);
        checkOutput({name, " aux"}, cur_aux, ex);
        checkOutput({name, " dz"}, 32'(cur_dz), 32'(ez));
        checkOutput({name, " in_ready busy"}, 32'(cur_in_ready), 32'd0);
        consume(name);
    endtask

    function automatic void model(input int w, input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic [31:0] x, output logic z);
        logic [63:0] mask;
        logic [63:0] p;
        mask = (64'd1 << w) - 64'd1;
        z = 1'b0;
        p = '0;
        case (op)
            2'd0: begin
                p = 64'(a) + 64'(b);
                r = 32'(p & mask);
                x = 32'((p >> w) & 64'd1);
            end
            2'd1: begin
                p = 64'(a) - 64'(b);
                r = 32'(p & mask);
                x = (a < b) ? 32'd1 : 32'd0;
            end
            2'd2: begin
                p = 64'(a) * 64'(b);
                r = 32'(p & mask);
                x = 32'((p >> w) & mask);
            end
            default: begin
                if (b == 0) begin
                    r = 32'(mask);
                    x = a;
                    z = 1'b1;
                end else begin
                    r = a / b;
                    x = a % b;
                end
            end
        endcase
    endfunction

    task automatic modelVector(input string name, input int w, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [31:0] x;
        logic        z;
        int          elat;
        model(w, op, a, b, r, x, z);
        elat = (op < 2'd2 || (op == 2'd3 && b == 0)) ? 2 : w + 1;
        doVector(name, op, a, b, r, x, z, elat);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] aux;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int lat;
        vecs[0]  = '{2'd0, 32'd200, 32'd100, 32'd44,   32'd1,    1'b0, 2};
        vecs[1]  = '{2'd1, 32'd5,   32'd7,   32'd254,  32'd1,    1'b0, 2};
        vecs[2]  = '{2'd1, 32'd7,   32'd5,   32'd2,    32'd0,    1'b0, 2};
        vecs[3]  = '{2'd2, 32'd200, 32'd200, 32'h40,   32'h9C,   1'b0, 9};
        vecs[4]  = '{2'd2, 32'd255, 32'd255, 32'h01,   32'hFE,   1'b0, 9};
        vecs[5]  = '{2'd3, 32'd255, 32'd16,  32'd15,   32'd15,   1'b0, 9};
        vecs[6]  = '{2'd3, 32'd37,  32'd0,   32'hFF,   32'd37,   1'b1, 2};
        vecs[7]  = '{2'd0, 32'd10,  32'd20,  32'd30,   32'd0,    1'b0, 2};
        vecs[8]  = '{2'd0, 32'd255, 32'd1,   32'd0,    32'd1,    1'b0, 2};
        vecs[9]  = '{2'd3, 32'd7,   32'd9,   32'd0,    32'd7,    1'b0, 9};
        vecs[10] = '{2'd2, 32'd0,   32'd123, 32'd0,    32'd0,    1'b0, 9};

        rst_n = 1'b0;
        #12;
        checkOutput("reset in_ready", 32'(cur_in_ready), 32'd0);
        checkOutput("reset out_valid", 32'(cur_out_valid), 32'd0);
        checkOutput("reset result", cur_result, 32'd0);
        checkOutput("reset aux", cur_aux, 32'd0);
        checkOutput("reset dz", 32'(cur_dz), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("in_ready after release", 32'(cur_in_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            doVector($sformatf("w8 vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                     vecs[i].res, vecs[i].aux, vecs[i].dz, vecs[i].lat);
        end

        // Backpressure: result held while extra requests are refused.
        applyStimulus(2'd2, 32'd13, 32'd11, lat);
        checkOutput("bp latency", 32'(lat), 32'd9);
        for (int i = 0; i < 5; i++) begin
            drv_valid = i[0];
            drv_op    = 2'd0;
            drv_a     = 32'd1;
            drv_b     = 32'd1;
            @(negedge clk);
            checkOutput("bp out_valid", 32'(cur_out_valid), 32'd1);
            checkOutput("bp result", cur_result, 32'h8F);
            checkOutput("bp aux", cur_aux, 32'd0);
            checkOutput("bp dz", 32'(cur_dz), 32'd0);
            checkOutput("bp in_ready", 32'(cur_in_ready), 32'd0);
        end
        drv_valid = 1'b0;
        consume("bp");
        repeat (4) @(negedge clk);
        checkOutput("bp no queued op", 32'(cur_out_valid), 32'd0);
        checkOutput("bp result held", cur_result, 32'h8F);

        // Reset in the middle of a multiply.
        @(negedge clk);
        drv_valid = 1'b1;
        drv_op    = 2'd2;
        drv_a     = 32'd99;
        drv_b     = 32'd77;
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset result", cur_result, 32'd0);
        checkOutput("midreset aux", cur_aux, 32'd0);
        checkOutput("midreset in_ready", 32'(cur_in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("midreset no out_valid", 32'(cur_out_valid), 32'd0);
        doVector("post reset add", 2'd0, 32'd10, 32'd20, 32'd30, 32'd0, 1'b0, 2);

        sel = 16;
        repeat (2) @(negedge clk);
        modelVector("w16 add", 16, 2'd0, 32'd60000, 32'd10000);
        modelVector("w16 sub", 16, 2'd1, 32'd3, 32'd65535);
        modelVector("w16 mul", 16, 2'd2, 32'd65535, 32'd65535);
        modelVector("w16 div", 16, 2'd3, 32'd50000, 32'd7);
        modelVector("w16 div0", 16, 2'd3, 32'd1234, 32'd0);
        for (int i = 0; i < 8; i++) begin
            modelVector($sformatf("w16 rnd%0d", i), 16, 2'(i % 4),
                        32'($urandom_range(0, 65535)), 32'($urandom_range(0, 65535)));
        end

        sel = 2;
        repeat (2) @(negedge clk);
        for (int o = 0; o < 4; o++) begin
            for (int v = 0; v < 16; v++) begin
                modelVector($sformatf("w2 op%0d a%0d b%0d", o, v / 4, v % 4), 2, 2'(o),
                            32'(v / 4), 32'(v % 4));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
